// File: rtl/sd_pixel_loader.sv
// sd_pixel_loader: skips a fixed image header from the SD byte stream, packs
// little-endian byte pairs into RGB565 pixels and writes them to the frame
// buffer with sequential addresses over a WIDTH x HEIGHT frame.
// Optional macro BMP_BOTTOM_UP_EN: emit addresses in bottom-up BMP row order.
module sd_pixel_loader #(
    parameter int WIDTH        = 320,
    parameter int HEIGHT       = 240,
    parameter int HEADER_BYTES = 54,
    parameter int ADDR_W       = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_data,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [15:0]       pixel_data,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              pixel_we,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SKIP = 3'd1;
    localparam logic [2:0] S_LO   = 3'd2;
    localparam logic [2:0] S_HI   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam int SKIP_W = (HEADER_BYTES > 1) ? $clog2(HEADER_BYTES) : 1;
    localparam logic [SKIP_W-1:0] SKIP_LAST =
        SKIP_W'((HEADER_BYTES > 0) ? HEADER_BYTES - 1 : 0);
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] WIDTH_A  = ADDR_W'(WIDTH);

    logic [2:0]        state_q, state_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [7:0]        lo_q, lo_d;
    logic [15:0]       data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] cur_addr;
    logic              accept;

    // Ready is a pure decode of the registered state.
    assign byte_ready = (state_q == S_SKIP) || (state_q == S_LO) || (state_q == S_HI);
    assign accept     = byte_valid && byte_ready;
    assign busy       = (state_q != S_IDLE);
    assign pixel_data = data_q;
    assign pixel_addr = addr_q;
    assign pixel_we   = we_q;
    assign frame_done = done_q;

    // Frame buffer address of the pixel currently being assembled.
    always_comb begin
`ifdef BMP_BOTTOM_UP_EN
        cur_addr = (ROW_LAST - row_q) * WIDTH_A + col_q;
`else
        cur_addr = row_q * WIDTH_A + col_q;
`endif
    end

    // Next-state, counter and output-register logic.
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        col_d   = col_q;
        row_d   = row_q;
        lo_d    = lo_q;
        data_d  = data_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    skip_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = (HEADER_BYTES == 0) ? S_LO : S_SKIP;
                end
            end
            S_SKIP: begin
                if (accept) begin
                    if (skip_q == SKIP_LAST) begin
                        state_d = S_LO;
                    end else begin
                        skip_d = skip_q + 1'b1;
                    end
                end
            end
            S_LO: begin
                if (accept) begin
                    lo_d    = byte_data;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (accept) begin
                    data_d = {byte_data, lo_q};
                    addr_d = cur_addr;
                    we_d   = 1'b1;
                    if ((row_q == ROW_LAST) && (col_q == COL_LAST)) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LO;
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            skip_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            lo_q    <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            col_q   <= col_d;
            row_q   <= row_d;
            lo_q    <= lo_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_sd_pixel_loader.sv
// Self-checking bench for sd_pixel_loader (4x2 frame, 4-byte header).
// Expected pixel writes are queued as bytes are driven; a monitor records
// every observed write / frame_done and each test drains the scoreboard.
module tb_sd_pixel_loader;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int HB = 4;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          byte_ready;
    logic [15:0]   pixel_data;
    logic [AW-1:0] pixel_addr;
    logic          pixel_we;
    logic          busy;
    logic          frame_done;

    always #5 clk = ~clk;

    sd_pixel_loader #(
        .WIDTH(W),
        .HEIGHT(H),
        .HEADER_BYTES(HB),
        .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .byte_data(byte_data),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .pixel_data(pixel_data),
        .pixel_addr(pixel_addr),
        .pixel_we(pixel_we),
        .busy(busy),
        .frame_done(frame_done)
    );

    typedef struct {
        logic [15:0]   data;
        logic [AW-1:0] addr;
        logic          we;
        logic          done;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    ev_t mon_e;
    int  rd_idx = 0;
    int  total  = 0;
    int  bad    = 0;

    // Record every write strobe or frame_done seen by the frame buffer side.
    always @(negedge clk) begin
        if (pixel_we || frame_done) begin
            mon_e.data = pixel_data;
            mon_e.addr = pixel_addr;
            mon_e.we   = pixel_we;
            mon_e.done = frame_done;
            obs_q.push_back(mon_e);
        end
    end

    function automatic logic [AW-1:0] exp_addr(input int i);
        int r;
        int c;
        r = i / W;
        c = i % W;
`ifdef BMP_BOTTOM_UP_EN
        return AW'((H - 1 - r) * W + c);
`else
        return AW'(r * W + c);
`endif
    endfunction

    task automatic push_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        while (!byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!byte_ready) begin
            total++;
            bad++;
            $display("FAIL byte_accept_timeout: byte_ready=%b required=1", byte_ready);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_header(input int gap_max);
        logic [7:0] hdr [4];
        hdr[0] = 8'hAA; hdr[1] = 8'hBB; hdr[2] = 8'hCC; hdr[3] = 8'hDD;
        for (int i = 0; i < HB; i++)
            push_byte(hdr[i], (gap_max > 0) ? $urandom_range(gap_max, 1) : 0);
    endtask

    task automatic stream_pixels(input int first, input int last,
                                 input int gap_max, input int start_at);
        logic [15:0] px;
        ev_t e;
        for (int i = first; i <= last; i++) begin
            px = (i == 0) ? 16'h1234 : 16'($urandom);
            e.data = px;
            e.addr = exp_addr(i);
            e.we   = 1'b1;
            e.done = (i == W * H - 1);
            exp_q.push_back(e);
            push_byte(px[7:0],  (gap_max > 0) ? $urandom_range(gap_max, 1) : 0);
            push_byte(px[15:8], (gap_max > 0) ? $urandom_range(gap_max, 1) : 0);
            if (i == start_at) pulse_start();
        end
    endtask

    task automatic scoreboard_drain(input string name);
        ev_t e;
        ev_t o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (rd_idx >= obs_q.size()) begin
                bad++;
                $display("FAIL %s missing_write: got none required data=%h addr=%0d done=%b",
                         name, e.data, e.addr, e.done);
            end else begin
                o = obs_q[rd_idx];
                rd_idx++;
                if (o.data !== e.data || o.addr !== e.addr || o.we !== e.we || o.done !== e.done) begin
                    bad++;
                    $display("FAIL %s write: got data=%h addr=%0d we=%b done=%b required data=%h addr=%0d we=%b done=%b",
                             name, o.data, o.addr, o.we, o.done, e.data, e.addr, e.we, e.done);
                end
            end
        end
        total++;
        if (obs_q.size() != rd_idx) begin
            bad++;
            $display("FAIL %s extra_events: got %0d unexpected required 0", name, obs_q.size() - rd_idx);
        end
        rd_idx = obs_q.size();
    endtask

    task automatic wait_done_and_idle(input string name);
        int t;
        t = 0;
        while (!frame_done && t < 20) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (frame_done !== 1'b1) begin
            bad++;
            $display("FAIL %s frame_done_timeout: got %b required 1", name, frame_done);
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_at_done: got %b required 1", name, busy);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || byte_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_after_done: got busy=%b ready=%b required 0 0", name, busy, byte_ready);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        start      = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
        total++;
        if (byte_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b required 0", byte_ready); end
        total++;
        if (pixel_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b required 0", pixel_we); end
        total++;
        if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b required 0", frame_done); end
        total++;
        if (pixel_data !== 16'h0) begin bad++; $display("FAIL reset_data: got %h required 0000", pixel_data); end
        total++;
        if (pixel_addr !== '0) begin bad++; $display("FAIL reset_addr: got %0d required 0", pixel_addr); end
    endtask

    task automatic test_idle_bytes();
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (byte_ready !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL idle_bytes: got ready=%b busy=%b required 0 0", byte_ready, busy);
            end
        end
        byte_valid = 1'b0;
        scoreboard_drain("idle_bytes");
    endtask

    task automatic test_first_pixel();
        pulse_start();
        send_header(0);
        stream_pixels(0, W * H - 1, 0, -1);
        wait_done_and_idle("first_pixel");
        scoreboard_drain("first_pixel");
    endtask

    task automatic test_stalls();
        pulse_start();
        send_header(5);
        stream_pixels(0, W * H - 1, 5, -1);
        wait_done_and_idle("stalls");
        scoreboard_drain("stalls");
    endtask

    task automatic test_start_mid();
        pulse_start();
        send_header(0);
        stream_pixels(0, W * H - 1, 0, 3);
        wait_done_and_idle("start_mid");
        scoreboard_drain("start_mid");
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send_header(0);
        stream_pixels(0, 2, 0, -1);
        push_byte(8'h77, 0);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || byte_ready !== 1'b0 || pixel_we !== 1'b0 || frame_done !== 1'b0 ||
            pixel_data !== 16'h0 || pixel_addr !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got busy=%b ready=%b we=%b done=%b data=%h addr=%0d required all 0",
                     busy, byte_ready, pixel_we, frame_done, pixel_data, pixel_addr);
        end
        reset = 1'b0;
        @(negedge clk);
        scoreboard_drain("reset_mid");
        pulse_start();
        send_header(0);
        stream_pixels(0, W * H - 1, 0, -1);
        wait_done_and_idle("reload");
        scoreboard_drain("reload");
    endtask

    initial begin
        test_reset();
        test_idle_bytes();
        test_first_pixel();
        test_stalls();
        test_start_mid();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
